// File: rtl/conv_1st_sched.sv
// conv_1st_sched: load/compute sequencer for the first-layer convolution datapath.
// Runs PRELOAD -> GAP -> ARM -> RUN -> DONE after a start pulse, driving memory
// read strobes/addresses, the datapath sta signal and progress status.
module conv_1st_sched #(
  parameter int unsigned FIG_DEPTH  = 75,
  parameter int unsigned BIAS_DEPTH = 34,
  parameter int unsigned W_TAPS     = 9,
  parameter int unsigned KERNELS    = 32,
  parameter int unsigned SLOT_LEN   = 18,
  parameter int unsigned ARM_LEN    = 300,
  parameter int unsigned GAP_LEN    = 8,
  parameter int unsigned PASSES     = 10,
  localparam int unsigned FAW = (FIG_DEPTH > 1) ? $clog2(FIG_DEPTH) : 1,
  localparam int unsigned BAW = (BIAS_DEPTH > 1) ? $clog2(BIAS_DEPTH) : 1,
  localparam int unsigned WAW = (W_TAPS * KERNELS > 1) ? $clog2(W_TAPS * KERNELS) : 1,
  localparam int unsigned PCW = $clog2(PASSES + 1),
  localparam int unsigned KIW = (KERNELS > 1) ? $clog2(KERNELS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            valid_i,
  output logic            scan_re,
  output logic [FAW-1:0]  scan_addr,
  output logic            bias_re,
  output logic [BAW-1:0]  bias_addr,
  output logic            w_re,
  output logic [WAW-1:0]  w_addr,
  output logic            dp_sta,
  output logic            busy,
  output logic            done,
  output logic [PCW-1:0]  pass_cnt,
  output logic [KIW-1:0]  kernel_idx,
  output logic [15:0]     out_cnt
);

  // Shared per-state cycle counter must cover the longest state / threshold.
  localparam int unsigned M0      = (FIG_DEPTH > ARM_LEN) ? FIG_DEPTH : ARM_LEN;
  localparam int unsigned M1      = (M0 > SLOT_LEN) ? M0 : SLOT_LEN;
  localparam int unsigned M2      = (M1 > GAP_LEN) ? M1 : GAP_LEN;
  localparam int unsigned M3      = (M2 > BIAS_DEPTH) ? M2 : BIAS_DEPTH;
  localparam int unsigned CYC_MAX = (M3 > W_TAPS) ? M3 : W_TAPS;
  localparam int unsigned CW      = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRELOAD, S_GAP, S_ARM, S_RUN, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            scan_re_q, scan_re_d;
  logic [FAW-1:0]  scan_addr_q, scan_addr_d;
  logic            bias_re_q, bias_re_d;
  logic [BAW-1:0]  bias_addr_q, bias_addr_d;
  logic            w_re_q, w_re_d;
  logic [WAW-1:0]  w_addr_q, w_addr_d;
  logic            dp_sta_q, dp_sta_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PCW-1:0]  pass_cnt_q, pass_cnt_d;
  logic [KIW-1:0]  kernel_idx_q, kernel_idx_d;
  logic [15:0]     out_cnt_q, out_cnt_d;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q + CW'(1);
    scan_re_d    = 1'b0;
    scan_addr_d  = scan_addr_q;
    bias_re_d    = 1'b0;
    bias_addr_d  = bias_addr_q;
    w_re_d       = 1'b0;
    w_addr_d     = w_addr_q;
    dp_sta_d     = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    pass_cnt_d   = pass_cnt_q;
    kernel_idx_d = kernel_idx_q;
    out_cnt_d    = out_cnt_q;

    // Weight address advances after every issued read, wrapping at the last word.
    if (w_re_q) begin
      w_addr_d = (w_addr_q == WAW'(W_TAPS * KERNELS - 1)) ? '0 : w_addr_q + WAW'(1);
    end
    if (dp_sta_q && valid_i && (out_cnt_q != 16'hFFFF)) begin
      out_cnt_d = out_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (start && !abort) begin
          state_d      = S_PRELOAD;
          out_cnt_d    = '0;
          pass_cnt_d   = '0;
          kernel_idx_d = '0;
        end
      end
      S_PRELOAD: if (cyc_q == CW'(FIG_DEPTH - 1)) begin
        state_d = S_GAP;
        cyc_d   = '0;
      end
      S_GAP: if (cyc_q == CW'(GAP_LEN - 1)) begin
        state_d  = S_ARM;
        cyc_d    = '0;
        w_addr_d = '0;
      end
      S_ARM: if (cyc_q == CW'(ARM_LEN - 1)) begin
        state_d = S_RUN;
        cyc_d   = '0;
      end
      S_RUN: if (cyc_q == CW'(SLOT_LEN - 1)) begin
        cyc_d = '0;
        if (kernel_idx_q == KIW'(KERNELS - 1)) begin
          kernel_idx_d = '0;
          pass_cnt_d   = pass_cnt_q + PCW'(1);
          if (pass_cnt_q == PCW'(PASSES - 1)) begin
            state_d = S_DONE;
          end
        end else begin
          kernel_idx_d = kernel_idx_q + KIW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
    endcase

    // Abort overrides every transition and freezes all counters and addresses.
    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      cyc_d        = '0;
      w_addr_d     = w_addr_q;
      pass_cnt_d   = pass_cnt_q;
      kernel_idx_d = kernel_idx_q;
      out_cnt_d    = out_cnt_q;
    end

    // Outputs follow the state/count being entered so they line up with the registers.
    case (state_d)
      S_PRELOAD: begin
        busy_d      = 1'b1;
        scan_re_d   = 1'b1;
        scan_addr_d = FAW'(cyc_d);
        if (cyc_d < CW'(BIAS_DEPTH)) begin
          bias_re_d   = 1'b1;
          bias_addr_d = BAW'(cyc_d);
        end
      end
      S_GAP: busy_d = 1'b1;
      S_ARM, S_RUN: begin
        busy_d   = 1'b1;
        dp_sta_d = 1'b1;
        w_re_d   = (cyc_d < CW'(W_TAPS));
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // State, counter and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      scan_re_q    <= 1'b0;
      scan_addr_q  <= '0;
      bias_re_q    <= 1'b0;
      bias_addr_q  <= '0;
      w_re_q       <= 1'b0;
      w_addr_q     <= '0;
      dp_sta_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_cnt_q   <= '0;
      kernel_idx_q <= '0;
      out_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      scan_re_q    <= scan_re_d;
      scan_addr_q  <= scan_addr_d;
      bias_re_q    <= bias_re_d;
      bias_addr_q  <= bias_addr_d;
      w_re_q       <= w_re_d;
      w_addr_q     <= w_addr_d;
      dp_sta_q     <= dp_sta_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_cnt_q   <= pass_cnt_d;
      kernel_idx_q <= kernel_idx_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

  assign scan_re    = scan_re_q;
  assign scan_addr  = scan_addr_q;
  assign bias_re    = bias_re_q;
  assign bias_addr  = bias_addr_q;
  assign w_re       = w_re_q;
  assign w_addr     = w_addr_q;
  assign dp_sta     = dp_sta_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_cnt   = pass_cnt_q;
  assign kernel_idx = kernel_idx_q;
  assign out_cnt    = out_cnt_q;

endmodule

// File: tb/tb_conv_1st_sched.sv
// tb_conv_1st_sched: bench for conv_1st_sched with a default and a reduced instance,
// checked cycle by cycle against a phase/arithmetic reference model.
module tb_conv_1st_sched;

  logic clk = 1'b0;
  logic rst;
  logic start, abort, valid_i;
  logic start_r, abort_r, valid_r;

  logic       scan_re, bias_re, w_re, dp_sta, busy, done;
  logic [6:0] scan_addr;
  logic [5:0] bias_addr;
  logic [8:0] w_addr;
  logic [3:0] pass_cnt;
  logic [4:0] kernel_idx;
  logic [15:0] out_cnt;

  logic       r_scan_re, r_bias_re, r_w_re, r_dp_sta, r_busy, r_done;
  logic [1:0] r_scan_addr;
  logic [0:0] r_bias_addr;
  logic [4:0] r_w_addr;
  logic [0:0] r_pass_cnt;
  logic [0:0] r_kernel_idx;
  logic [15:0] r_out_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_1st_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .valid_i(valid_i),
    .scan_re(scan_re), .scan_addr(scan_addr), .bias_re(bias_re), .bias_addr(bias_addr),
    .w_re(w_re), .w_addr(w_addr), .dp_sta(dp_sta), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .kernel_idx(kernel_idx), .out_cnt(out_cnt)
  );

  conv_1st_sched #(
    .FIG_DEPTH(4), .BIAS_DEPTH(2), .W_TAPS(9), .KERNELS(2), .SLOT_LEN(10),
    .ARM_LEN(12), .GAP_LEN(1), .PASSES(1)
  ) dut_r (
    .clk(clk), .rst(rst), .start(start_r), .abort(abort_r), .valid_i(valid_r),
    .scan_re(r_scan_re), .scan_addr(r_scan_addr), .bias_re(r_bias_re), .bias_addr(r_bias_addr),
    .w_re(r_w_re), .w_addr(r_w_addr), .dp_sta(r_dp_sta), .busy(r_busy), .done(r_done),
    .pass_cnt(r_pass_cnt), .kernel_idx(r_kernel_idx), .out_cnt(r_out_cnt)
  );

  typedef struct {
    int fig; int bias; int wt; int ker; int slot; int arm; int gap; int pas;
  } cfg_t;

  typedef struct {
    bit scan_re; int scan_addr; bit bias_re; int bias_addr; bit w_re; int w_addr;
    bit dp_sta; bit busy; bit done; int pass_cnt; int kernel_idx; int out_cnt;
  } obs_t;

  // Expected outputs in cycle c after the start edge (c=1 is the first PRELOAD cycle).
  function automatic obs_t model(cfg_t p, int c, int rd, int oc);
    obs_t e;
    int g_end, a_end, r_end, t;
    e = '{default: 0};
    g_end = p.fig + p.gap;
    a_end = g_end + p.arm;
    r_end = a_end + p.pas * p.ker * p.slot;
    e.out_cnt = oc;
    e.busy    = (c >= 1 && c <= r_end);
    e.done    = (c == r_end + 1);
    e.dp_sta  = (c > g_end && c <= r_end);
    if (c >= 1 && c <= p.fig) begin
      e.scan_re = 1'b1;
      e.scan_addr = c - 1;
      if (c <= p.bias) begin
        e.bias_re = 1'b1;
        e.bias_addr = c - 1;
      end
    end
    if (c > g_end && c <= a_end) e.w_re = ((c - g_end - 1) < p.wt);
    if (c > a_end && c <= r_end) begin
      t = c - a_end - 1;
      e.w_re = ((t % p.slot) < p.wt);
      e.kernel_idx = (t / p.slot) % p.ker;
      e.pass_cnt = t / (p.slot * p.ker);
    end
    if (c > r_end) e.pass_cnt = p.pas;
    e.w_addr = rd % (p.wt * p.ker);
    return e;
  endfunction

  function automatic bit same(obs_t o, obs_t e);
    return (o.scan_re == e.scan_re) && (o.bias_re == e.bias_re) && (o.w_re == e.w_re) &&
           (o.dp_sta == e.dp_sta) && (o.busy == e.busy) && (o.done == e.done) &&
           (o.pass_cnt == e.pass_cnt) && (o.kernel_idx == e.kernel_idx) &&
           (o.out_cnt == e.out_cnt) &&
           (!e.scan_re || o.scan_addr == e.scan_addr) &&
           (!e.bias_re || o.bias_addr == e.bias_addr) &&
           (!e.w_re || o.w_addr == e.w_addr);
  endfunction

  function automatic obs_t sample(bit r);
    obs_t o;
    if (r) begin
      o.scan_re = r_scan_re; o.scan_addr = int'(r_scan_addr);
      o.bias_re = r_bias_re; o.bias_addr = int'(r_bias_addr);
      o.w_re = r_w_re; o.w_addr = int'(r_w_addr);
      o.dp_sta = r_dp_sta; o.busy = r_busy; o.done = r_done;
      o.pass_cnt = int'(r_pass_cnt); o.kernel_idx = int'(r_kernel_idx); o.out_cnt = int'(r_out_cnt);
    end else begin
      o.scan_re = scan_re; o.scan_addr = int'(scan_addr);
      o.bias_re = bias_re; o.bias_addr = int'(bias_addr);
      o.w_re = w_re; o.w_addr = int'(w_addr);
      o.dp_sta = dp_sta; o.busy = busy; o.done = done;
      o.pass_cnt = int'(pass_cnt); o.kernel_idx = int'(kernel_idx); o.out_cnt = int'(out_cnt);
    end
    return o;
  endfunction

  // Sum of every output field; zero only when all outputs are zero.
  function automatic int nonzero(obs_t o);
    return int'(o.scan_re) + o.scan_addr + int'(o.bias_re) + o.bias_addr + int'(o.w_re) +
           o.w_addr + int'(o.dp_sta) + int'(o.busy) + int'(o.done) + o.pass_cnt +
           o.kernel_idx + o.out_cnt;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse (or hold) start, then compare ncyc cycles against the model.
  task automatic do_run(input bit r, input cfg_t p, input int ncyc, input bit hold, input bit vone,
                        output int mism, output int first_bad, output int reads, output int biasn,
                        output int donen, output int done_at, output int dp_rise,
                        output int wraps, output int last_out);
    obs_t o, e;
    int rd, oc, prev;
    bit v;
    mism = 0; first_bad = -1; reads = 0; biasn = 0; donen = 0; done_at = -1;
    dp_rise = -1; wraps = 0; last_out = -1; rd = 0; oc = 0; prev = -1;
    if (r) start_r = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= ncyc; c++) begin
      if (!hold) begin
        if (r) start_r = 1'b0; else start = 1'b0;
      end
      o = sample(r);
      e = model(p, c, rd, oc);
      if (!same(o, e)) begin
        mism++;
        if (first_bad < 0) first_bad = c;
      end
      if (e.w_re) rd++;
      if (o.w_re) begin
        if (prev == p.wt * p.ker - 1 && o.w_addr == 0) wraps++;
        prev = o.w_addr;
        reads++;
      end
      if (o.bias_re) biasn++;
      if (o.done) begin
        donen++;
        done_at = c;
      end
      if (o.dp_sta && dp_rise < 0) dp_rise = c;
      last_out = o.out_cnt;
      v = vone ? 1'b1 : 1'($urandom_range(0, 1));
      if (r) valid_r = v; else valid_i = v;
      if (e.dp_sta && v) oc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    cfg_t cd, cr;
    obs_t o;
    int mism, fb, reads, biasn, donen, done_at, dp_rise, wraps, last_out, n_done, n_busy;

    cd = '{fig: 75, bias: 34, wt: 9, ker: 32, slot: 18, arm: 300, gap: 8, pas: 10};
    cr = '{fig: 4, bias: 2, wt: 9, ker: 2, slot: 10, arm: 12, gap: 1, pas: 1};
    rst = 1'b1; start = 1'b0; abort = 1'b0; valid_i = 1'b0;
    start_r = 1'b0; abort_r = 1'b0; valid_r = 1'b0;

    // Reset state.
    #12;
    chk("reset_outputs_default", nonzero(sample(0)), 0);
    chk("reset_outputs_reduced", nonzero(sample(1)), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reduced parameter run.
    do_run(1, cr, 40, 0, 0, mism, fb, reads, biasn, donen, done_at, dp_rise, wraps, last_out);
    chk($sformatf("trace_reduced first_bad_cycle=%0d", fb), mism, 0);
    chk("reduced_done_cycle", done_at, 38);
    chk("reduced_done_pulses", donen, 1);
    chk("reduced_w_reads", reads, 27);
    chk("reduced_w_wrap_17_to_0", wraps, 1);

    // Default run with random valid_i.
    do_run(0, cd, 6145, 0, 0, mism, fb, reads, biasn, donen, done_at, dp_rise, wraps, last_out);
    chk($sformatf("trace_default first_bad_cycle=%0d", fb), mism, 0);
    chk("default_done_cycle", done_at, 6144);
    chk("default_done_pulses", donen, 1);
    chk("default_bias_re_cycles", biasn, 34);
    chk("default_dp_sta_rise", dp_rise, 84);
    chk("default_w_reads", reads, 2889);
    chk("default_w_wraps", wraps, 10);
    chk("default_pass_cnt_final", int'(pass_cnt), 10);

    // Abort during ARM at cycle 200, restart at cycle 210.
    do_run(0, cd, 199, 0, 0, mism, fb, reads, biasn, donen, done_at, dp_rise, wraps, last_out);
    chk($sformatf("trace_pre_abort first_bad_cycle=%0d", fb), mism, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    o = sample(0);
    chk("abort_busy", int'(o.busy), 0);
    chk("abort_dp_sta", int'(o.dp_sta), 0);
    chk("abort_strobes", int'(o.scan_re) + int'(o.bias_re) + int'(o.w_re), 0);
    n_done = 0; n_busy = 0;
    for (int i = 201; i < 210; i++) begin
      o = sample(0);
      n_done += int'(o.done);
      n_busy += int'(o.busy);
      @(posedge clk); #1;
    end
    chk("abort_no_done", n_done, 0);
    chk("abort_stays_idle", n_busy, 0);
    do_run(0, cd, 6145, 0, 0, mism, fb, reads, biasn, donen, done_at, dp_rise, wraps, last_out);
    chk($sformatf("trace_restart first_bad_cycle=%0d", fb), mism, 0);
    chk("restart_done_cycle", done_at, 6144);

    // Asynchronous reset in the middle of RUN.
    do_run(0, cd, 1000, 0, 0, mism, fb, reads, biasn, donen, done_at, dp_rise, wraps, last_out);
    chk($sformatf("trace_pre_rst first_bad_cycle=%0d", fb), mism, 0);
    chk("pre_rst_in_run", int'(dp_sta), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs_zero", nonzero(sample(0)), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", nonzero(sample(0)), 0);
    do_run(0, cd, 6145, 0, 0, mism, fb, reads, biasn, donen, done_at, dp_rise, wraps, last_out);
    chk($sformatf("trace_post_rst first_bad_cycle=%0d", fb), mism, 0);
    chk("post_rst_done_cycle", done_at, 6144);

    // start held high with valid_i tied to 1.
    do_run(0, cd, 6145, 1, 1, mism, fb, reads, biasn, donen, done_at, dp_rise, wraps, last_out);
    chk($sformatf("trace_start_held first_bad_cycle=%0d", fb), mism, 0);
    chk("held_done_pulses", donen, 1);
    chk("held_out_cnt", last_out, 6060);
    o = sample(0);
    chk("held_restart_scan_re", int'(o.scan_re), 1);
    chk("held_restart_scan_addr", o.scan_addr, 0);
    chk("held_restart_out_cnt", o.out_cnt, 0);
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("final_abort_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_1st_sched.md
# conv_1st_sched

Top-level sequencer for the first-layer convolution datapath `conv_1st_top`. After a single `start` pulse it runs the full load/compute schedule:

- read addresses and read strobes for the figure, bias and weight memories, which feed `scan_i`/`bias_i`/`weight_i` directly;
- the datapath `sta` signal;
- progress and completion status back to the system.

It replaces the hand-timed stimulus sequence with a synthesizable FSM.

## Interface

Parameters:
- FIG_DEPTH, 75, figure words preloaded per run
- BIAS_DEPTH, 34, bias words preloaded (issued during the first BIAS_DEPTH preload cycles)
- W_TAPS, 9, weight words per kernel
- KERNELS, 32, kernels per pass
- SLOT_LEN, 18, cycles per kernel slot in RUN
- ARM_LEN, 300, pre-allocation cycles with `dp_sta` high before RUN
- GAP_LEN, 8, idle cycles between PRELOAD and ARM
- PASSES, 10, full kernel sweeps per run

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  run request, sampled only in IDLE
- abort  in  1  synchronous abort, returns to IDLE
- valid_i  in  1  `conv_1st_top` `valid_o`
- scan_re  out  1  figure memory read enable
- scan_addr  out  clog2(FIG_DEPTH)  figure memory address
- bias_re  out  1  bias memory read enable
- bias_addr  out  clog2(BIAS_DEPTH)  bias memory address
- w_re  out  1  weight memory read enable
- w_addr  out  clog2(W_TAPS*KERNELS)  weight memory address
- dp_sta  out  1  drives `conv_1st_top` `sta`
- busy  out  1  high in PRELOAD, GAP, ARM and RUN
- done  out  1  one-cycle pulse at normal completion
- pass_cnt  out  clog2(PASSES+1)  completed passes
- kernel_idx  out  clog2(KERNELS)  current slot within a pass
- out_cnt  out  16  `valid_i` beats counted while `dp_sta`=1; saturates at 0xFFFF

## Operation

- States: IDLE, PRELOAD, GAP, ARM, RUN, DONE. A single down/up cycle counter `cyc` is reused per state.
- **IDLE:** all strobes 0 and `dp_sta`=0. `start`=1 → PRELOAD. Counters (`out_cnt`, `pass_cnt`, `kernel_idx`) clear on entry to PRELOAD.
- **PRELOAD:** FIG_DEPTH cycles.
  - `scan_re`=1, `scan_addr`=`cyc` (0..FIG_DEPTH-1).
  - `bias_re`=1 with `bias_addr`=`cyc` while `cyc`<BIAS_DEPTH, else `bias_re`=0 (address holds).
  - Then → GAP.
- **GAP:** GAP_LEN cycles, all strobes 0. Then → ARM.
- **ARM:** ARM_LEN cycles, `dp_sta`=1.
  - `w_re`=1 for `cyc`<W_TAPS, with `w_addr` 0..W_TAPS-1.
  - Then → RUN with `w_addr`=W_TAPS.
- **RUN:** PASSES×KERNELS×SLOT_LEN cycles, `dp_sta`=1.
  - Slot counter `s` runs 0..SLOT_LEN-1.
  - `w_re`=1 while `s`<W_TAPS; `w_addr` increments after each issued read and wraps from W_TAPS×KERNELS-1 to 0.
  - `kernel_idx` increments at `s`=SLOT_LEN-1 and wraps KERNELS-1→0; that wrap increments `pass_cnt`.
  - After the last cycle of pass PASSES → DONE.
- **DONE:** one cycle, `done`=1, `dp_sta`=0, `busy`=0. Then → IDLE. `pass_cnt`/`out_cnt` hold until the next start.
- `start` outside IDLE is ignored.
- `abort`=1 in any non-IDLE state → IDLE next cycle: all strobes and `dp_sta` 0, `done` not pulsed, counters hold. `abort` has priority over all state transitions.
- When `start` and `abort` are both high in IDLE, `abort` wins and the FSM stays in IDLE.
- `rst`: asynchronous clear of every register. Reset values:
  - state=IDLE;
  - all outputs 0, including all addresses, `busy`, `done` and `out_cnt`.

  This holds mid-run; no partial state is retained.
- Address outputs are registered: a read enable and its address change in the same cycle, and the memory delivers data one cycle later.

## Timing

- `start` is sampled at edge T0. PRELOAD covers cycles T0+1..T0+FIG_DEPTH: `scan_addr`=0 with `scan_re`=1 in cycle T0+1.
- Defaults:
  - PRELOAD 1..75;
  - GAP 76..83;
  - ARM 84..383;
  - RUN 384..6143;
  - DONE with `done`=1 at cycle 6144;
  - IDLE from 6145.
- `dp_sta` rises in cycle 84 and falls in cycle 6144.
- `busy` covers 1..6143.
- Weight reads per RUN slot are cycles 0..8 of each 18; total weight reads = 9 + 10×288.
- `out_cnt` is incremented the cycle after a sampled `valid_i`&`dp_sta`.

## Test plan

- **Default run:** `start` pulse at T0 →
  - `scan_addr` 0..74 on cycles 1..75;
  - `bias_re` exactly 34 cycles;
  - `dp_sta` rises at cycle 84;
  - `done` single pulse at cycle 6144;
  - `pass_cnt`=10.
- **Weight sequencing:** log `w_addr` on every `w_re` →
  - ARM issues 0..8;
  - RUN issues 9..287 then 0..;
  - no `w_re` when slot position ≥9;
  - wrap 287→0 occurs, with exactly 2889 reads total.
- **Abort at cycle 200** (ARM) → IDLE at 201 with `dp_sta`/`busy` 0 and no `done`. A new `start` at 210 restarts from `scan_addr`=0 with `out_cnt` cleared.
- **Async `rst`** asserted mid-RUN between clock edges → all outputs 0 immediately, before the next edge. After release the FSM is in IDLE and a `start` then completes normally.
- **`start` held high** throughout a run plus `valid_i` tied to 1 →
  - no restart until after DONE;
  - `out_cnt` = 6060, i.e. every `dp_sta` cycle counted;
  - a second run starts from the IDLE cycle at 6145.
- **Reduced parameters** (FIG_DEPTH=4, BIAS_DEPTH=2, KERNELS=2, SLOT_LEN=10, PASSES=1, ARM_LEN=12, GAP_LEN=1) → `done` at cycle 1+4+1+12+20 = 38; `w_addr` wraps 17→0.
